// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared SSP receive/transmit types and constants
package ssp_pkg;
  localparam int SSP_DATA_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} rx_state_t;
endpackage

// File: rtl/ssp_rx_ctrl_if.sv
// rtl/ssp_rx_ctrl_if.sv - serial-side inputs and RxFIFO-side outputs of the SSP receive controller
interface ssp_rx_ctrl_if import ssp_pkg::*; #(parameter int DATA_WIDTH = SSP_DATA_WIDTH);
  logic                  SSE;
  logic                  SSPCLKIN;
  logic                  SSPFSSIN;
  logic                  SSPRXD;
  logic                  SSPRXINTR;
  logic                  RORIC;
  logic [DATA_WIDTH-1:0] RxData;
  logic                  write_ready;
  logic                  SSPRORINTR;
  logic                  rx_busy;

  modport master (
    output SSE, SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR, RORIC,
    input  RxData, write_ready, SSPRORINTR, rx_busy
  );

  modport slave (
    input  SSE, SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR, RORIC,
    output RxData, write_ready, SSPRORINTR, rx_busy
  );
endinterface

// File: rtl/ssp_edge_detect.sv
// rtl/ssp_edge_detect.sv - serial clock edge detector in the PCLK domain
// Resets the delayed copy low so no falling edge is reported out of reset.
module ssp_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  output logic fall,
  output logic rise
);
  logic sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sclk_q <= 1'b0;
    else     sclk_q <= sclk;
  end

  assign fall = sclk_q & ~sclk;
  assign rise = ~sclk_q & sclk;
endmodule

// File: rtl/ssp_rx_ctrl.sv
// rtl/ssp_rx_ctrl.sv - SSP receive controller: frame sync, MSB-first deserialise, RxFIFO commit
// Overrun is sticky until RORIC; a full RxFIFO drops the byte but RxData still updates.
module ssp_rx_ctrl import ssp_pkg::*; #(
  parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
  input logic          PCLK,
  input logic          CLEAR,
  ssp_rx_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  rx_state_t             state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-2:0] shreg;
  logic                  rearm;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  ror;
  logic                  fall;
  logic                  sclk_rise_unused;
  logic                  shift_en;
  logic                  last_bit;

  ssp_edge_detect u_edge (
    .clk  (PCLK),
    .rst  (CLEAR),
    .sclk (bus.SSPCLKIN),
    .fall (fall),
    .rise (sclk_rise_unused)
  );

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (fall && bus.SSPFSSIN && bus.SSE) state_next = SHIFT;
      end
      SHIFT: begin
        if (!bus.SSE) begin
          state_next = IDLE;
        end else if (fall) begin
          shift_en = 1'b1;
          if (cnt == LAST_BIT) begin
            last_bit   = 1'b1;
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_next = (rearm && bus.SSE) ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The LSB goes straight into RxData so the byte is presentable in the commit cycle.
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      cnt     <= '0;
      shreg   <= '0;
      rearm   <= 1'b0;
      rx_data <= '0;
      ror     <= 1'b0;
    end else begin
      if (shift_en)            cnt <= last_bit ? '0 : cnt + 1'b1;
      else if (state != SHIFT) cnt <= '0;
      if (shift_en) shreg <= {shreg[DATA_WIDTH-3:0], bus.SSPRXD};
      if (last_bit) begin
        rx_data <= {shreg, bus.SSPRXD};
        rearm   <= bus.SSPFSSIN;
      end
      if (state == COMMIT && bus.SSPRXINTR) ror <= 1'b1;
      else if (bus.RORIC)                   ror <= 1'b0;
    end
  end

  // The full flag qualifies the strobe in the commit cycle itself.
  assign bus.write_ready = (state == COMMIT) && !bus.SSPRXINTR;
  assign bus.RxData      = rx_data;
  assign bus.SSPRORINTR  = ror;
  assign bus.rx_busy     = (state != IDLE);
endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// tb/tb_ssp_rx_ctrl.sv - scoreboard bench for ssp_rx_ctrl with directed and random frames
module tb_ssp_rx_ctrl;
  import ssp_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic PCLK = 1'b0;
  logic CLEAR;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_expected = 0;
  int   n_strobes = 0;
  logic prev_wr = 1'b0;
  logic exp_ror = 1'b0;
  exp_t exp_q[$];

  ssp_rx_ctrl_if #(.DATA_WIDTH(SSP_DATA_WIDTH)) bus ();

  ssp_rx_ctrl #(.DATA_WIDTH(SSP_DATA_WIDTH)) dut (
    .PCLK  (PCLK),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One serial period: data changes with the rising half, DUT samples at the falling edge.
  task automatic send_bit(input logic fss, input logic d, input int half, input bit roric_commit);
    bus.SSPCLKIN = 1'b1;
    bus.SSPFSSIN = fss;
    bus.SSPRXD   = d;
    repeat (half) tick();
    bus.SSPCLKIN = 1'b0;
    if (roric_commit) begin
      tick();
      bus.RORIC = 1'b1;
      tick();
      bus.RORIC = 1'b0;
      repeat (half - 2) tick();
    end else begin
      repeat (half) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int half, input bit header,
                            input bit fss_last, input bit noise, input bit expect_write,
                            input bit roric_commit);
    if (header) send_bit(1'b1, 1'($urandom), half, 1'b0);
    for (int p = 0; p < 8; p++) begin
      logic fss;
      fss = (p == 7) ? fss_last : (noise && p >= 1 && p <= 6);
      if (p == 7 && expect_write) begin
        exp_q.push_back('{data: data, due: cyc + half + 1});
        n_expected++;
      end
      send_bit(fss, data[7-p], half, (p == 7) ? roric_commit : 1'b0);
    end
    if (!expect_write) exp_ror = 1'b1;
  endtask

  always @(negedge PCLK) begin
    if (!CLEAR) begin
      if (bus.write_ready) begin
        exp_t e;
        n_strobes++;
        chk("write_ready_back_to_back", prev_wr, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_ready", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", bus.RxData, e.data);
          chk("write_latency_cycle", cyc, e.due);
        end
      end
      prev_wr = bus.write_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.SSE = 1'b0; bus.SSPCLKIN = 1'b0; bus.SSPFSSIN = 1'b0; bus.SSPRXD = 1'b0;
    bus.SSPRXINTR = 1'b0; bus.RORIC = 1'b0;
    CLEAR = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_rx_data", bus.RxData, 8'h00);
    chk("reset_write_ready", bus.write_ready, 1'b0);
    chk("reset_ror", bus.SSPRORINTR, 1'b0);
    chk("reset_busy", bus.rx_busy, 1'b0);
    CLEAR = 1'b0;
    tick();
    bus.SSE = 1'b1;

    send_frame(8'hA5, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("single_idle_busy", bus.rx_busy, 1'b0);
    chk("single_hold_data", bus.RxData, 8'hA5);

    send_frame(8'h3C, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("b2b_idle_busy", bus.rx_busy, 1'b0);

    bus.SSPRXINTR = 1'b1;
    send_frame(8'h5A, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("overrun_rx_data", bus.RxData, 8'h5A);
    chk("overrun_set", bus.SSPRORINTR, 1'b1);
    repeat (10) tick();
    chk("overrun_sticky", bus.SSPRORINTR, 1'b1);
    send_frame(8'h96, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("overrun_set_wins", bus.SSPRORINTR, 1'b1);
    chk("overrun_rx_data2", bus.RxData, 8'h96);
    bus.RORIC = 1'b1;
    tick();
    bus.RORIC = 1'b0;
    chk("overrun_cleared", bus.SSPRORINTR, 1'b0);
    bus.SSPRXINTR = 1'b0;
    exp_ror = 1'b0;

    send_bit(1'b1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'($urandom), 2, 1'b0);
    chk("abort_busy_before", bus.rx_busy, 1'b1);
    bus.SSE = 1'b0;
    tick();
    chk("abort_idle_next", bus.rx_busy, 1'b0);
    repeat (4) tick();
    bus.SSE = 1'b1;
    send_frame(8'h81, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();

    send_frame(8'h0F, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("noise_idle_busy", bus.rx_busy, 1'b0);

    begin
      bit header = 1'b1;
      for (int n = 0; n < 30; n++) begin
        logic [7:0] d;
        int half;
        bit chain;
        d = 8'($urandom);
        half = $urandom_range(1, 3);
        chain = (n != 29) && ($urandom_range(0, 2) == 0);
        if (header) bus.SSPRXINTR = ($urandom_range(0, 3) == 0);
        send_frame(d, half, header, chain, 1'($urandom), !bus.SSPRXINTR, 1'b0);
        if (!chain) begin
          repeat (2) tick();
          chk("random_ror", bus.SSPRORINTR, exp_ror);
          if ($urandom_range(0, 1) == 1) begin
            bus.RORIC = 1'b1;
            tick();
            bus.RORIC = 1'b0;
            exp_ror = 1'b0;
          end
        end
        header = !chain;
      end
      bus.SSPRXINTR = 1'b0;
    end

    bus.SSPRXINTR = 1'b1;
    send_frame(8'hE7, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    bus.SSPRXINTR = 1'b0;
    chk("pre_clear_ror", bus.SSPRORINTR, 1'b1);
    send_bit(1'b1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom), 2, 1'b0);
    tick();
    #2;
    CLEAR = 1'b1;
    #1;
    chk("clear_async_rx_data", bus.RxData, 8'h00);
    chk("clear_async_write_ready", bus.write_ready, 1'b0);
    chk("clear_async_ror", bus.SSPRORINTR, 1'b0);
    chk("clear_async_busy", bus.rx_busy, 1'b0);
    exp_ror = 1'b0;
    bus.SSPCLKIN = 1'b0;
    bus.SSPFSSIN = 1'b0;
    repeat (2) tick();
    CLEAR = 1'b0;
    repeat (2) tick();
    send_frame(8'hFF, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("after_clear_rx_data", bus.RxData, 8'hFF);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk("pending_writes", exp_q.size(), 0);
    chk("strobe_count", n_strobes, n_expected);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
